// File: rtl/riscv_sim_pkg.sv
// Shared types and helpers for the core run/dump controller.
package riscv_sim_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_RUN,
      S_RD_REQ,
      S_RD_WAIT,
      S_OUT,
      S_DONE
   } state_e;

   localparam logic SRC_REG = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // Index width wide enough for the larger of the two dumped arrays.
   function automatic int idx_width(input int num_regs, input int mem_words);
      int n;
      n = (num_regs > mem_words) ? num_regs : mem_words;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Debug read port and dump stream between the controller and the host/core side.
interface cpu_run_controller_if #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 7
);
   logic             rd_en_o;
   logic             rd_is_mem_o;
   logic [IDX_W-1:0] rd_addr_o;
   logic [XLEN-1:0]  rd_data_i;

   logic             out_valid_o;
   logic             out_ready_i;
   logic             out_is_mem_o;
   logic [IDX_W-1:0] out_index_o;
   logic [XLEN-1:0]  out_data_o;

   modport master (
      output rd_en_o, rd_is_mem_o, rd_addr_o,
      input  rd_data_i,
      output out_valid_o, out_is_mem_o, out_index_o, out_data_o,
      input  out_ready_i
   );

   modport slave (
      input  rd_en_o, rd_is_mem_o, rd_addr_o,
      output rd_data_i,
      input  out_valid_o, out_is_mem_o, out_index_o, out_data_o,
      output out_ready_i
   );
endinterface

// File: rtl/cpu_run_controller_halt_detector.sv
// Flags a halt once the PC has stayed unchanged for STALL_LIMIT consecutive cycles.
module halt_detector #(
   parameter int XLEN        = 32,
   parameter int STALL_LIMIT = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            clear,
   input  logic [XLEN-1:0] pc_i,
   output logic            halt_o
);
   localparam int               CNT_W     = $clog2(STALL_LIMIT);
   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT - 1);

   logic [XLEN-1:0]  prev_pc_q;
   logic [CNT_W-1:0] stall_q;
   logic             first_q;
   logic             same_pc;

   assign same_pc = (pc_i == prev_pc_q);

   // first_q marks the opening cycle after clear, where prev_pc is not yet meaningful.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         prev_pc_q <= '0;
         stall_q   <= '0;
         first_q   <= 1'b1;
      end else if (clear) begin
         stall_q   <= '0;
         first_q   <= 1'b1;
      end else begin
         prev_pc_q <= pc_i;
         first_q   <= 1'b0;
         if (first_q || !same_pc)
            stall_q <= '0;
         else if (stall_q != STALL_MAX)
            stall_q <= stall_q + 1'b1;
      end
   end

   assign halt_o = !clear && !first_q && same_pc && (stall_q == STALL_MAX);

endmodule

// File: rtl/cpu_run_controller.sv
// Run/dump controller: resets and runs the core, detects halt/timeout, then streams regs and memory.
module cpu_run_controller
   import riscv_sim_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_REGS     = 32,
   parameter int MEM_WORDS    = 128,
   parameter int RESET_CYCLES = 6,
   parameter int MAX_CYCLES   = 500,
   parameter int STALL_LIMIT  = 16,
   parameter int IDX_W        = idx_width(NUM_REGS, MEM_WORDS)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   input  logic [XLEN-1:0]      pc_i,
   output logic                 cpu_rstn_o,
   output logic                 cpu_clk_en_o,
   cpu_run_controller_if.master dbg,
   output logic                 running_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic [31:0]          cycle_count_o
);
   localparam int               RST_W    = $clog2(RESET_CYCLES + 1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [31:0]      CYC_LAST = 32'(MAX_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

   state_e           state_q;
   logic [RST_W-1:0] rst_cnt_q;
   logic [31:0]      cycle_q, cycle_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             src_q, src_d;
   logic             last_beat;
   logic [XLEN-1:0]  data_q;
   logic             cpu_rstn_q, clk_en_q, rd_en_q, out_valid_q;
   logic             running_q, done_q, timeout_q;
   logic             halt;

   halt_detector #(
      .XLEN        (XLEN),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_halt (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (state_q != S_RUN),
      .pc_i   (pc_i),
      .halt_o (halt)
   );

   assign cycle_d = (&cycle_q) ? cycle_q : cycle_q + 32'd1;

   // Walk registers first, then memory; wrap the index on every source switch.
   always_comb begin
      idx_d     = idx_q + 1'b1;
      src_d     = src_q;
      last_beat = 1'b0;
      if (src_q == SRC_REG && idx_q == LAST_REG) begin
         idx_d = '0;
         src_d = SRC_MEM;
      end else if (src_q == SRC_MEM && idx_q == LAST_MEM) begin
         idx_d     = '0;
         src_d     = SRC_REG;
         last_beat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         cycle_q     <= '0;
         idx_q       <= '0;
         src_q       <= SRC_REG;
         data_q      <= '0;
         cpu_rstn_q  <= 1'b0;
         clk_en_q    <= 1'b0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q    <= S_CRST;
                  rst_cnt_q  <= '0;
                  cycle_q    <= '0;
                  timeout_q  <= 1'b0;
                  done_q     <= 1'b0;
                  cpu_rstn_q <= 1'b0;
                  clk_en_q   <= 1'b1;
               end
            end
            S_CRST: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_q    <= S_RUN;
                  cpu_rstn_q <= 1'b1;
                  running_q  <= 1'b1;
               end else begin
                  rst_cnt_q <= rst_cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               cycle_q <= cycle_d;
               // Halt takes priority over a budget expiry in the same cycle.
               if (halt || cycle_q == CYC_LAST) begin
                  state_q   <= S_RD_REQ;
                  timeout_q <= !halt;
                  running_q <= 1'b0;
                  clk_en_q  <= 1'b0;
                  rd_en_q   <= 1'b1;
                  idx_q     <= '0;
                  src_q     <= SRC_REG;
               end
            end
            S_RD_REQ: state_q <= S_RD_WAIT;
            S_RD_WAIT: begin
               data_q      <= dbg.rd_data_i;
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (dbg.out_ready_i) begin
                  out_valid_q <= 1'b0;
                  idx_q       <= idx_d;
                  src_q       <= src_d;
                  if (last_beat) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RD_REQ;
                     rd_en_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_rstn_o       = cpu_rstn_q;
   assign cpu_clk_en_o     = clk_en_q;
   assign running_o        = running_q;
   assign done_o           = done_q;
   assign timeout_o        = timeout_q;
   assign cycle_count_o    = cycle_q;
   assign dbg.rd_en_o      = rd_en_q;
   assign dbg.rd_is_mem_o  = src_q;
   assign dbg.rd_addr_o    = idx_q;
   assign dbg.out_valid_o  = out_valid_q;
   assign dbg.out_is_mem_o = src_q;
   assign dbg.out_index_o  = idx_q;
   assign dbg.out_data_o   = data_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for the run/dump controller with a small core PC and debug-read model.
module tb_cpu_run_controller;
   import riscv_sim_pkg::*;

   localparam int XLEN = 32;
   localparam int NR   = 4;
   localparam int MW   = 4;
   localparam int IW   = 2;

   typedef struct packed {
      logic            is_mem;
      logic [IW-1:0]   idx;
      logic [XLEN-1:0] data;
   } beat_t;

   logic            clk   = 1'b0;
   logic            rstn  = 1'b0;
   logic            start = 1'b0;
   logic [XLEN-1:0] pc;
   logic            cpu_rstn, cpu_en, running, done, timeout;
   logic [31:0]     ccount;

   cpu_run_controller_if #(.XLEN(XLEN), .IDX_W(IW)) dbg();

   cpu_run_controller #(
      .XLEN(XLEN), .NUM_REGS(NR), .MEM_WORDS(MW), .RESET_CYCLES(3),
      .MAX_CYCLES(20), .STALL_LIMIT(4), .IDX_W(IW)
   ) dut (
      .clk(clk), .rstn(rstn), .start_i(start), .pc_i(pc),
      .cpu_rstn_o(cpu_rstn), .cpu_clk_en_o(cpu_en), .dbg(dbg),
      .running_o(running), .done_o(done), .timeout_o(timeout),
      .cycle_count_o(ccount)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Debug-read contents and the expected dump table (hand-entered, independent copies).
   logic [XLEN-1:0] reg_m [NR] = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd7};
   logic [XLEN-1:0] mem_m [MW] = '{32'd1, 32'd2, 32'd3, 32'd4};
   logic [XLEN-1:0] exp_tab [8] = '{32'd0, 32'd5, 32'hFFFF_FFFD, 32'd7,
                                    32'd1, 32'd2, 32'd3, 32'd4};

   beat_t exp_q[$];

   // Core model: PC steps by 4 per RUN cycle, optionally freezing at 0x10; reads answer a cycle later.
   int            n_run   = 0;
   bit            pc_sat  = 1'b1;
   bit            rd_pend = 1'b0;
   logic          rd_pend_mem;
   logic [IW-1:0] rd_pend_addr;

   always @(negedge clk) begin
      if (!cpu_rstn) n_run = 0;
      else if (running) n_run++;
      pc = XLEN'((pc_sat && n_run > 4) ? 16 : n_run * 4);
      if (rd_pend) dbg.rd_data_i = rd_pend_mem ? mem_m[rd_pend_addr] : reg_m[rd_pend_addr];
      else dbg.rd_data_i = 32'hDEAD_BEEF;
      rd_pend      = dbg.rd_en_o;
      rd_pend_mem  = dbg.rd_is_mem_o;
      rd_pend_addr = dbg.rd_addr_o;
   end

   // Monitor: drives ready, checks hold-stability and pops the scoreboard on each handshake.
   int    beat_tot  = 0;
   int    beat_base = 0;
   int    stall_at  = -1;
   int    hold_at   = -1;
   int    stall_cnt = 0;
   bit    stab_chk  = 1'b0;
   beat_t snap;

   always @(negedge clk) begin
      beat_t cur, e;
      int    bn;
      cur.is_mem = dbg.out_is_mem_o;
      cur.idx    = dbg.out_index_o;
      cur.data   = dbg.out_data_o;
      bn = beat_tot - beat_base;
      if (stab_chk) begin
         check("hold_valid", dbg.out_valid_o, 1);
         check("hold_beat", cur, snap);
      end
      if (dbg.out_valid_o && bn == hold_at) dbg.out_ready_i = 1'b0;
      else if (dbg.out_valid_o && bn == stall_at && stall_cnt < 5) begin
         dbg.out_ready_i = 1'b0;
         stall_cnt++;
      end else dbg.out_ready_i = 1'b1;
      stab_chk = dbg.out_valid_o && !dbg.out_ready_i && rstn;
      snap = cur;
      if (dbg.out_valid_o && dbg.out_ready_i && rstn) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_extra: got 0x%0h with nothing expected", cur);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d", bn), cur, e);
         end
         beat_tot++;
         stall_cnt = 0;
      end
   end

   task automatic push_dump();
      beat_t b;
      beat_base = beat_tot;
      for (int k = 0; k < 8; k++) begin
         b.is_mem = (k >= 4);
         b.idx    = IW'(k % 4);
         b.data   = exp_tab[k];
         exp_q.push_back(b);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_phase(input int exp_cycles, input bit exp_to);
      int crst = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (running) break;
         if (!cpu_rstn && cpu_en) crst++;
      end
      check("crst_cycles", crst, 3);
      check("run_entry", running, 1);
      check("run_cnt0", ccount, 0);
      check("run_flags_clr", {done, timeout}, 2'b00);
      check("run_core", {cpu_rstn, cpu_en}, 2'b11);
      @(negedge clk);
      check("run_cnt1", ccount, 1);
      for (int i = 0; i < 100 && running; i++) @(negedge clk);
      check("run_exit", running, 0);
      check("exit_timeout", timeout, exp_to);
      check("exit_cycles", ccount, exp_cycles);
      check("exit_core", {cpu_rstn, cpu_en}, 2'b10);
      check("exit_rd_en", dbg.rd_en_o, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !done; i++) @(negedge clk);
      check("done", done, 1);
      check("done_core", {cpu_rstn, cpu_en}, 2'b10);
      check("done_valid", dbg.out_valid_o, 0);
      check("sb_empty", exp_q.size(), 0);
      check("beat_count", beat_tot - beat_base, 8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_core", {cpu_rstn, cpu_en}, 2'b00);
      check("rst_flags", {running, done, timeout, dbg.rd_en_o, dbg.out_valid_o}, 5'b0);
      check("rst_cnt", ccount, 0);
      @(posedge clk); #1 rstn = 1'b1;

      // Run 1: PC freezes at 0x10 -> halt after 8 RUN cycles; stall beat R2 for 5 cycles.
      pc_sat   = 1'b1;
      stall_at = 2;
      push_dump();
      pulse_start();
      run_phase(8, 1'b0);
      wait_done();
      check("r1_timeout", timeout, 0);
      stall_at = -1;

      // Run 2: PC always moving -> timeout after 20 RUN cycles; restart from DONE.
      pc_sat = 1'b0;
      push_dump();
      pulse_start();
      run_phase(20, 1'b1);
      wait_done();
      repeat (3) @(negedge clk);
      check("done_hold", {done, timeout}, 2'b11);
      check("done_cnt_hold", ccount, 20);

      // Run 3: reset lands while beat M1 is being presented.
      pc_sat  = 1'b1;
      hold_at = 5;
      push_dump();
      pulse_start();
      run_phase(8, 1'b0);
      for (int i = 0; i < 200 && !(dbg.out_valid_o && dbg.out_is_mem_o && dbg.out_index_o == 2'd1); i++)
         @(negedge clk);
      check("m1_present", {dbg.out_valid_o, dbg.out_is_mem_o, dbg.out_index_o}, 4'b1101);
      check("m1_beat_no", beat_tot - beat_base, 5);
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1;
      check("abort_valid", dbg.out_valid_o, 0);
      check("abort_core", {cpu_rstn, cpu_en}, 2'b00);
      check("abort_flags", {running, done, timeout, dbg.rd_en_o}, 4'b0);
      check("abort_cnt", ccount, 0);
      rstn    = 1'b1;
      hold_at = -1;
      exp_q.delete();

      // Run 4: clean rerun from IDLE after the abort.
      push_dump();
      pulse_start();
      run_phase(8, 1'b0);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
